// File: rtl/aib_cfg_bus_arb.sv
// Round-robin arbiter sharing the AIB config register bus between NumMasters requesters.
// Optional BUSY-state abort with sticky error flag: define AIB_CFG_ARB_TIMEOUT_EN.
module aib_cfg_bus_arb #(
  parameter int NumMasters = 2,
  parameter int TimeoutCyc = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NumMasters-1:0]      i_m_penable,
  input  logic [NumMasters-1:0]      i_m_pwrite,
  input  logic [NumMasters*32-1:0]   i_m_paddr,
  input  logic [NumMasters*32-1:0]   i_m_pwdata,
  output logic [NumMasters-1:0]      o_m_pready,
  output logic [31:0]                o_m_prdata,
  output logic                       o_s_penable,
  output logic                       o_s_pwrite,
  output logic [31:0]                o_s_paddr,
  output logic [31:0]                o_s_pwdata,
  input  logic                       i_s_pready,
  input  logic [31:0]                i_s_prdata,
  output logic [2:0]                 o_grant,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_ptr;
  logic [2:0]  r_grant;
  logic [2:0]  w_winner;
  int          w_dist;
  int          w_bestDist;
  logic        w_anyReq;
  logic        w_selReq;
  logic        w_selWrite;
  logic [31:0] w_selAddr;
  logic [31:0] w_selWdata;

  if (NumMasters < 2 || NumMasters > 8 || TimeoutCyc < 1) begin : g_badParam
    $error("aib_cfg_bus_arb: NumMasters must be 2..8 and TimeoutCyc >= 1");
  end

  assign w_anyReq = |i_m_penable;
  assign o_busy   = (r_state != StIdle);
  assign o_grant  = r_grant;

  // Lowest rotated distance from ptr+1 wins, so the last completer ends up last in line.
  always_comb begin
    w_winner   = '0;
    w_bestDist = NumMasters;
    w_dist     = 0;
    for (int m = 0; m < NumMasters; m++) begin
      w_dist = (m + 2 * NumMasters - 1 - int'(r_ptr)) % NumMasters;
      if (i_m_penable[m] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        w_winner   = 3'(m);
      end
    end
  end

  always_comb begin
    w_selReq   = 1'b0;
    w_selWrite = 1'b0;
    w_selAddr  = '0;
    w_selWdata = '0;
    for (int m = 0; m < NumMasters; m++) begin
      if (r_grant == 3'(m)) begin
        w_selReq   = i_m_penable[m];
        w_selWrite = i_m_pwrite[m];
        w_selAddr  = i_m_paddr[32*m +: 32];
        w_selWdata = i_m_pwdata[32*m +: 32];
      end
    end
  end

`ifdef AIB_CFG_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCyc + 1);

  logic [CntW-1:0] r_busyCnt;
  logic            r_timeoutErr;
  logic            w_timeoutHit;

  assign o_timeout_err = r_timeoutErr;
`else
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    o_s_penable = 1'b0;
    o_s_pwrite  = 1'b0;
    o_s_paddr   = '0;
    o_s_pwdata  = '0;
    o_m_pready  = '0;
    o_m_prdata  = '0;
`ifdef AIB_CFG_ARB_TIMEOUT_EN
    w_timeoutHit = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (w_anyReq) w_nextState = StBusy;
      end
      StBusy: begin
        o_s_penable = 1'b1;
        o_s_pwrite  = w_selWrite;
        o_s_paddr   = w_selAddr;
        o_s_pwdata  = w_selWdata;
        // A master abandoning its request is dropped silently rather than completed.
        if (!w_selReq) begin
          w_nextState = StGap;
        end else if (i_s_pready) begin
          for (int m = 0; m < NumMasters; m++) begin
            if (r_grant == 3'(m)) o_m_pready[m] = 1'b1;
          end
          o_m_prdata  = i_s_prdata;
          w_nextState = StGap;
        end
`ifdef AIB_CFG_ARB_TIMEOUT_EN
        else if (r_busyCnt == CntW'(TimeoutCyc - 1)) begin
          for (int m = 0; m < NumMasters; m++) begin
            if (r_grant == 3'(m)) o_m_pready[m] = 1'b1;
          end
          o_m_prdata   = 32'hDEAD_BEEF;
          w_timeoutHit = 1'b1;
          w_nextState  = StGap;
        end
`endif
      end
      StGap: begin
        w_nextState = StIdle;
      end
      default: begin
        w_nextState = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ptr   <= 3'(NumMasters - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == StIdle) && w_anyReq) r_grant <= w_winner;
      if ((r_state == StBusy) && (|o_m_pready)) r_ptr <= r_grant;
    end
  end

`ifdef AIB_CFG_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busyCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if ((r_state == StIdle) && w_anyReq) begin
        r_busyCnt <= '0;
      end else if (r_state == StBusy) begin
        r_busyCnt <= r_busyCnt + 1'b1;
      end
      if (w_timeoutHit) r_timeoutErr <= 1'b1;
    end
  end
`endif

endmodule
